aes_job_scheduler: RTL

- Shares one byte-serial AES engine between two requesters (client 0, client 1).
- Each client presents a 128-bit key and a 128-bit plaintext in parallel. The scheduler arbitrates round-robin and serialises the winner's key and plaintext onto the engine's din/cmd port.
- It issues start, collects 16 ciphertext bytes from dout/data_ok and returns the 128-bit ciphertext to the winning client.
- Sits between the system bus and the engine top level.

---
 rtl/aes_job_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_job_scheduler.sv
// ---------------------------------------------------------------------------
// aes_job_scheduler
// Shares one byte-serial AES engine between two clients. A round-robin
// arbiter picks a client, the key and plaintext are streamed MSB byte first
// onto the engine cmd/din port, encryption is started, and 16 ciphertext
// bytes are gathered and returned to the winner. A job aborts with an error
// if the ciphertext does not complete within TIMEOUT cycles of the start.
//
// Ports
//   clk, rst_              clock, asynchronous active-low reset
//   req_valid/req_ready    per-client request handshake (2 bits each)
//   req_key0/1, req_pt0/1  client key and plaintext, sampled at accept
//   rsp_valid              per-client one-cycle response pulse
//   rsp_err                1 = job aborted by timeout
//   rsp_data               128-bit ciphertext (0 on timeout)
//   busy                   scheduler is not idle
//   eng_din/eng_cmd        byte and command to the engine
//   eng_ready              engine can take a command this cycle
//   eng_dout/eng_data_ok   ciphertext byte stream from the engine
// ---------------------------------------------------------------------------
module aes_job_scheduler #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_key0,
  input  logic [127:0] req_key1,
  input  logic [127:0] req_pt0,
  input  logic [127:0] req_pt1,
  output logic [1:0]   rsp_valid,
  output logic         rsp_err,
  output logic [127:0] rsp_data,
  output logic         busy,
  output logic [7:0]   eng_din,
  output logic [1:0]   eng_cmd,
  input  logic         eng_ready,
  input  logic [7:0]   eng_dout,
  input  logic         eng_data_ok
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_KEY   = 2'b01;
  localparam logic [1:0] CMD_PT    = 2'b10;
  localparam logic [1:0] CMD_START = 2'b11;

  // Abort decision is taken one cycle early so that rsp_valid is seen
  // exactly TIMEOUT cycles after the start command.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_PT  = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  state_e             state_q,     state_d;
  logic               ptr_q,       ptr_d;
  logic               gnt_q,       gnt_d;
  logic [BLK_W-1:0]   key_q,       key_d;
  logic [BLK_W-1:0]   pt_q,        pt_d;
  logic [BLK_W-1:0]   res_q,       res_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [TO_W-1:0]    to_q,        to_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [BLK_W-1:0]   rsp_data_q,  rsp_data_d;
  logic               pick_c;

  // Next-state, datapath and engine command decode
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    key_d       = key_q;
    pt_d        = pt_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    req_ready   = 2'b00;
    eng_cmd     = CMD_NOP;
    eng_din     = '0;
    // A lone requester wins outright; on contention the pointer decides.
    pick_c      = (req_valid == 2'b11) ? ptr_q : req_valid[1];

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready        = 2'b00;
          req_ready[pick_c] = rst_;
          gnt_d            = pick_c;
          ptr_d            = ~pick_c;
          key_d            = pick_c ? req_key1 : req_key0;
          pt_d             = pick_c ? req_pt1  : req_pt0;
          cnt_d            = '0;
          state_d          = ST_LOAD_KEY;
        end
      end

      // Key and plaintext are shifted out from the top byte.
      ST_LOAD_KEY: begin
        if (eng_ready) begin
          eng_cmd = CMD_KEY;
          eng_din = key_q[BLK_W-1 -: BYTE_W];
          key_d   = {key_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(15)) state_d = ST_LOAD_PT;
        end
      end

      ST_LOAD_PT: begin
        if (eng_ready) begin
          eng_cmd = CMD_PT;
          eng_din = pt_q[BLK_W-1 -: BYTE_W];
          pt_d    = {pt_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(15)) state_d = ST_START;
        end
      end

      ST_START: begin
        if (eng_ready) begin
          eng_cmd = CMD_START;
          to_d    = '0;
          cnt_d   = '0;
          state_d = ST_WAIT_OUT;
        end
      end

      // Ciphertext bytes shift in at the bottom; byte 0 ends up on top.
      // A 16th byte arriving on the abort cycle still completes the job.
      ST_WAIT_OUT: begin
        to_d = to_q + TO_W'(1);
        if (eng_data_ok) begin
          res_d = {res_q[BLK_W-BYTE_W-1:0], eng_dout};
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (eng_data_ok && (cnt_q == CNT_W'(15))) begin
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          rsp_data_d  = res_d;
          state_d     = ST_RESP;
        end else if (to_q == TO_LAST) begin
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered response outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      key_q       <= '0;
      pt_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
